// File: rtl/glyph_rom_streamer_pkg.sv
// Shared glyph geometry, the default digit bitmaps and the streamer FSM states.
// Row 0 of each glyph comes first; bit 15 of a row is the leftmost pixel.
package glyph_pkg;
  localparam int GLYPH_W_DEF = 16;
  localparam int GLYPH_H_DEF = 16;
  localparam int DIGIT_COUNT = 10;

  localparam logic [15:0] DIGIT_ROM [DIGIT_COUNT][16] = '{
    '{16'h0000, 16'h07E0, 16'h0FF0, 16'h1C38, 16'h1818, 16'h1818, 16'h1818, 16'h1818,
      16'h1818, 16'h1818, 16'h1818, 16'h1818, 16'h1C38, 16'h0FF0, 16'h07E0, 16'h0000},
    '{16'h0000, 16'h0180, 16'h0380, 16'h0780, 16'h0D80, 16'h0180, 16'h0180, 16'h0180,
      16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h0180, 16'h07E0, 16'h07E0, 16'h0000},
    '{16'h0000, 16'h07E0, 16'h0FF0, 16'h1C38, 16'h0018, 16'h0038, 16'h0070, 16'h00E0,
      16'h01C0, 16'h0380, 16'h0700, 16'h0E00, 16'h1C00, 16'h1FF8, 16'h1FF8, 16'h0000},
    '{16'h0000, 16'h3FF0, 16'h7FF8, 16'h0007, 16'h0007, 16'h0007, 16'h000E, 16'h03FC,
      16'h0FF8, 16'h1FFF, 16'h000E, 16'h0007, 16'h0007, 16'h7FFE, 16'h3FFC, 16'h0000},
    '{16'h0000, 16'h0070, 16'h00F0, 16'h01B0, 16'h0330, 16'h0630, 16'h0C30, 16'h1830,
      16'h1FFC, 16'h1FFC, 16'h0030, 16'h0030, 16'h0030, 16'h0030, 16'h0030, 16'h0000},
    '{16'h0000, 16'h1FF8, 16'h1FF8, 16'h1800, 16'h1800, 16'h1FE0, 16'h1FF0, 16'h0038,
      16'h0018, 16'h0018, 16'h0018, 16'h0018, 16'h1838, 16'h1FF0, 16'h0FE0, 16'h0000},
    '{16'h0000, 16'h03E0, 16'h07F0, 16'h0E00, 16'h1C00, 16'h1800, 16'h1FE0, 16'h1FF0,
      16'h1C38, 16'h1818, 16'h1818, 16'h1818, 16'h1C38, 16'h0FF0, 16'h07E0, 16'h0000},
    '{16'h0000, 16'h1FF8, 16'h1FF8, 16'h0018, 16'h0030, 16'h0060, 16'h00C0, 16'h0180,
      16'h0300, 16'h0300, 16'h0300, 16'h0300, 16'h0300, 16'h0300, 16'h0300, 16'h0000},
    '{16'h0000, 16'h07E0, 16'h0FF0, 16'h1818, 16'h1818, 16'h1818, 16'h0FF0, 16'h07E0,
      16'h0FF0, 16'h1818, 16'h1818, 16'h1818, 16'h1818, 16'h0FF0, 16'h07E0, 16'h0000},
    '{16'h0000, 16'h07E0, 16'h0FF0, 16'h1C38, 16'h1818, 16'h1818, 16'h1C38, 16'h0FF8,
      16'h07F8, 16'h0018, 16'h0038, 16'h0070, 16'h00E0, 16'h07C0, 16'h0F80, 16'h0000}
  };

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/glyph_rom_streamer_if.sv
// Row-streaming valid/ready channel from the glyph streamer to the template-compare stage.
interface glyph_rom_streamer_if
  import glyph_pkg::*;
#(
  parameter int GLYPH_W = GLYPH_W_DEF,
  parameter int RB      = idxWidth(GLYPH_H_DEF)
) ();
  logic               row_valid;
  logic               row_ready;
  logic [GLYPH_W-1:0] row_data;
  logic [RB-1:0]      row_idx;
  logic               row_last;

  modport master (output row_valid, row_data, row_idx, row_last, input row_ready);
  modport slave  (input row_valid, row_data, row_idx, row_last, output row_ready);
endinterface

// File: rtl/glyph_rom_streamer_rom.sv
// Constant glyph store with two registered read ports; glyph indices past the table read zero.
module glyph_rom
  import glyph_pkg::*;
#(
  parameter int GLYPH_W    = GLYPH_W_DEF,
  parameter int NUM_GLYPHS = DIGIT_COUNT,
  parameter int GB         = idxWidth(NUM_GLYPHS),
  parameter int RB         = idxWidth(GLYPH_H_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [GB-1:0]      i_a_glyph,
  input  logic [RB-1:0]      i_a_row,
  output logic [GLYPH_W-1:0] o_a_data,
  input  logic [GB-1:0]      i_b_glyph,
  input  logic [RB-1:0]      i_b_row,
  output logic [GLYPH_W-1:0] o_b_data
);
  function automatic logic [GLYPH_W-1:0] fetch(input logic [GB-1:0] g, input logic [RB-1:0] r);
    logic [GLYPH_W-1:0] v;
    v = '0;
    if (int'(g) < NUM_GLYPHS && int'(g) < DIGIT_COUNT)
      v = GLYPH_W'(DIGIT_ROM[g][r]);
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_a_data <= '0;
      o_b_data <= '0;
    end else begin
      o_a_data <= fetch(i_a_glyph, i_a_row);
      o_b_data <= fetch(i_b_glyph, i_b_row);
    end
  end
endmodule

// File: rtl/glyph_rom_streamer.sv
// Glyph ROM with a free-running display read port and a row-by-row streaming engine.
// The stream read address is steered one cycle ahead so row_data lines up with row_idx.
module glyph_rom_streamer
  import glyph_pkg::*;
#(
  parameter int GLYPH_W    = GLYPH_W_DEF,
  parameter int GLYPH_H    = GLYPH_H_DEF,
  parameter int NUM_GLYPHS = DIGIT_COUNT,
  parameter int MIRROR_EN  = 1,
  localparam int GB        = idxWidth(NUM_GLYPHS),
  localparam int RB        = idxWidth(GLYPH_H)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [GB-1:0]      disp_glyph,
  input  logic [RB-1:0]      disp_row,
  output logic [GLYPH_W-1:0] disp_data,
  input  logic               start,
  input  logic [GB-1:0]      start_glyph,
  input  logic               mirror,
  input  logic               abort,
  output logic               busy,
  output logic               err,
  output logic               done,
  glyph_rom_streamer_if.master strm
);
  state_t             r_state, w_next;
  logic [GB-1:0]      r_glyph;
  logic               r_mirror;
  logic [RB-1:0]      r_row;
  logic               r_err;
  logic               w_in_range, w_accept, w_hs, w_last;
  logic [GB-1:0]      w_rd_glyph;
  logic [RB-1:0]      w_rd_row;
  logic [GLYPH_W-1:0] w_rom_row, w_row_out;

  assign w_in_range = int'(start_glyph) < NUM_GLYPHS;
  assign w_accept   = (r_state == IDLE) & start & w_in_range;
  assign w_hs       = (r_state == STREAM) & strm.row_ready;
  assign w_last     = (r_row == RB'(GLYPH_H - 1));

  // Next state plus the address the stream port must read for the following cycle.
  always_comb begin
    w_next     = r_state;
    w_rd_glyph = r_glyph;
    w_rd_row   = r_row;
    unique case (r_state)
      IDLE: begin
        w_rd_glyph = start_glyph;
        w_rd_row   = '0;
        if (w_accept) w_next = STREAM;
      end
      STREAM: begin
        if (abort) begin
          w_next = IDLE;
        end else if (w_hs) begin
          if (w_last) w_next = DONE;
          else        w_rd_row = r_row + 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_glyph  <= '0;
      r_mirror <= 1'b0;
      r_row    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == IDLE) & start & ~w_in_range;
      if (w_accept) begin
        r_glyph  <= start_glyph;
        r_mirror <= mirror & (MIRROR_EN != 0);
        r_row    <= '0;
      end else if (w_hs && !abort && !w_last) begin
        r_row <= r_row + 1'b1;
      end
    end
  end

  glyph_rom #(
    .GLYPH_W    (GLYPH_W),
    .NUM_GLYPHS (NUM_GLYPHS),
    .GB         (GB),
    .RB         (RB)
  ) u_rom (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_a_glyph (disp_glyph),
    .i_a_row   (disp_row),
    .o_a_data  (disp_data),
    .i_b_glyph (w_rd_glyph),
    .i_b_row   (w_rd_row),
    .o_b_data  (w_rom_row)
  );

  // Mirroring touches only the stream path; the display port always sees the stored row.
  always_comb begin
    w_row_out = w_rom_row;
    if (r_mirror)
      for (int i = 0; i < GLYPH_W; i++) w_row_out[i] = w_rom_row[GLYPH_W-1-i];
  end

  assign strm.row_valid = (r_state == STREAM);
  assign strm.row_data  = w_row_out;
  assign strm.row_idx   = r_row;
  assign strm.row_last  = (r_state == STREAM) & w_last;
  assign busy           = (r_state == STREAM);
  assign done           = (r_state == DONE);
  assign err            = r_err;
endmodule

// File: tb/tb_glyph_rom_streamer.sv
// Directed bench for glyph_rom_streamer: display port, streaming, stalls, mirror, errors, abort, reset.
module tb_glyph_rom_streamer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  disp_glyph, disp_row, start_glyph;
  logic        start, mirror, abort;
  logic [15:0] disp_data0, disp_data1;
  logic        busy0, busy1, err0, err1, done0, done1;
  int          checks = 0;
  int          failures = 0;
  int          expIdx;
  logic        rdy;
  logic [31:0] pat;
  logic [15:0] g3 [16];

  always #5 clk = ~clk;

  glyph_rom_streamer_if #(.GLYPH_W(16), .RB(4)) sif0 ();
  glyph_rom_streamer_if #(.GLYPH_W(16), .RB(4)) sif1 ();

  glyph_rom_streamer #(.MIRROR_EN(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .disp_glyph(disp_glyph), .disp_row(disp_row),
    .disp_data(disp_data0), .start(start), .start_glyph(start_glyph), .mirror(mirror),
    .abort(abort), .busy(busy0), .err(err0), .done(done0), .strm(sif0)
  );

  glyph_rom_streamer #(.MIRROR_EN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .disp_glyph(disp_glyph), .disp_row(disp_row),
    .disp_data(disp_data1), .start(start), .start_glyph(start_glyph), .mirror(mirror),
    .abort(abort), .busy(busy1), .err(err1), .done(done1), .strm(sif1)
  );

  function automatic logic [15:0] rev16(input logic [15:0] x);
    return {<<{x}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] g, input logic m,
                               input logic a, input logic r);
    start            = s;
    start_glyph      = g;
    mirror           = m;
    abort            = a;
    sif0.row_ready   = r;
    sif1.row_ready   = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    g3 = '{16'h0000, 16'h3FF0, 16'h7FF8, 16'h0007, 16'h0007, 16'h0007, 16'h000E, 16'h03FC,
           16'h0FF8, 16'h1FFF, 16'h000E, 16'h0007, 16'h0007, 16'h7FFE, 16'h3FFC, 16'h0000};
    pat = 32'hB4D2_6A39;

    // Reset state
    rst_n = 1'b0;
    disp_glyph = 4'd0;
    disp_row = 4'd0;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("rst disp_data", disp_data0, 16'h0000);
    checkOutput("rst busy", busy0, 1'b0);
    checkOutput("rst err", err0, 1'b0);
    checkOutput("rst done", done0, 1'b0);
    checkOutput("rst row_valid", sif0.row_valid, 1'b0);
    checkOutput("rst row_data", sif0.row_data, 16'h0000);
    checkOutput("rst row_idx", sif0.row_idx, 4'd0);
    checkOutput("rst row_last", sif0.row_last, 1'b0);

    // Display port
    rst_n = 1'b1;
    disp_glyph = 4'd3;
    disp_row = 4'd3;
    step();
    checkOutput("disp g3r3", disp_data0, 16'h0007);
    checkOutput("disp g3r3 dut1", disp_data1, 16'h0007);
    disp_row = 4'd9;
    step();
    checkOutput("disp g3r9", disp_data0, 16'h1FFF);
    disp_glyph = 4'd12;
    step();
    checkOutput("disp g12 zero", disp_data0, 16'h0000);
    disp_glyph = 4'd3;
    disp_row = 4'd3;

    // Full-rate stream of glyph 3
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 4'd3, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("t2 valid r%0d", i), sif0.row_valid, 1'b1);
      checkOutput($sformatf("t2 idx r%0d", i), sif0.row_idx, i[3:0]);
      checkOutput($sformatf("t2 data r%0d", i), sif0.row_data, g3[i]);
      checkOutput($sformatf("t2 last r%0d", i), sif0.row_last, (i == 15) ? 1'b1 : 1'b0);
      checkOutput($sformatf("t2 done r%0d", i), done0, 1'b0);
      step();
    end
    checkOutput("t2 done pulse", done0, 1'b1);
    checkOutput("t2 done busy", busy0, 1'b0);
    checkOutput("t2 done valid", sif0.row_valid, 1'b0);
    step();
    checkOutput("t2 done once", done0, 1'b0);

    // Stalled stream with irregular ready
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    step();
    expIdx = 0;
    for (int c = 0; c < 80 && expIdx < 16; c++) begin
      checkOutput($sformatf("t3 valid c%0d", c), sif0.row_valid, 1'b1);
      checkOutput($sformatf("t3 idx c%0d", c), sif0.row_idx, expIdx);
      checkOutput($sformatf("t3 data c%0d", c), sif0.row_data, g3[expIdx]);
      rdy = pat[c % 32];
      applyStimulus(1'b0, 4'd3, 1'b0, 1'b0, rdy);
      step();
      if (rdy) expIdx++;
    end
    checkOutput("t3 rows accepted", expIdx, 16);
    checkOutput("t3 done pulse", done0, 1'b1);
    step();

    // Mirror honoured by dut0, ignored by dut1
    applyStimulus(1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 4'd3, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("t4 mir r%0d", i), sif0.row_data, rev16(g3[i]));
      checkOutput($sformatf("t4 nomir r%0d", i), sif1.row_data, g3[i]);
      if (i == 3) begin
        checkOutput("t4 mir r3 const", sif0.row_data, 16'hE000);
        checkOutput("t4 nomir r3 const", sif1.row_data, 16'h0007);
        checkOutput("t4 disp unmirrored", disp_data0, 16'h0007);
      end
      step();
    end
    checkOutput("t4 done dut0", done0, 1'b1);
    checkOutput("t4 done dut1", done1, 1'b1);
    step();

    // Out-of-range start and start while busy
    applyStimulus(1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("t5 err g12", err0, 1'b1);
    checkOutput("t5 err g12 busy", busy0, 1'b0);
    checkOutput("t5 err g12 valid", sif0.row_valid, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("t5 err one cycle", err0, 1'b0);
    applyStimulus(1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("t5 err g10", err1, 1'b1);
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("t5 started", sif0.row_valid, 1'b1);
    applyStimulus(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("t5 busy start no err", err0, 1'b0);
    checkOutput("t5 busy start idx", sif0.row_idx, 4'd0);
    checkOutput("t5 busy start data", sif0.row_data, g3[0]);
    applyStimulus(1'b0, 4'd5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("t5 data r%0d", i), sif0.row_data, g3[i]);
      step();
    end
    checkOutput("t5 done pulse", done0, 1'b1);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("t5 start in done ignored", sif0.row_valid, 1'b0);
    checkOutput("t5 start in done busy", busy0, 1'b0);
    checkOutput("t5 start in done err", err0, 1'b0);

    // Abort at row 5 together with ready
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 4'd3, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step();
    checkOutput("t6 at row5", sif0.row_idx, 4'd5);
    applyStimulus(1'b0, 4'd3, 1'b0, 1'b1, 1'b1);
    step();
    checkOutput("t6 abort valid", sif0.row_valid, 1'b0);
    checkOutput("t6 abort busy", busy0, 1'b0);
    checkOutput("t6 abort done", done0, 1'b0);
    applyStimulus(1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("t6 abort no late done", done0, 1'b0);

    // Abort with start in IDLE still starts
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b1, 1'b1);
    step();
    checkOutput("t6 abort+start valid", sif0.row_valid, 1'b1);
    checkOutput("t6 abort+start idx", sif0.row_idx, 4'd0);

    // Reset pulsed mid-stream
    applyStimulus(1'b0, 4'd3, 1'b0, 1'b0, 1'b1);
    step();
    step();
    checkOutput("t6 pre-reset idx", sif0.row_idx, 4'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("t6 reset valid", sif0.row_valid, 1'b0);
    checkOutput("t6 reset busy", busy0, 1'b0);
    checkOutput("t6 reset data", sif0.row_data, 16'h0000);
    checkOutput("t6 reset idx", sif0.row_idx, 4'd0);
    step();
    checkOutput("t6 reset no done", done0, 1'b0);
    rst_n = 1'b1;
    step();
    checkOutput("t6 post-reset idle", sif0.row_valid, 1'b0);
    checkOutput("t6 post-reset done", done0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
